// File: rtl/dm_stage.sv
// Data-memory stage: byte-masked stores and zero/sign-extended loads, registered into writeback with a misalignment/range error flag.
// Loads and flags appear one cycle after MEM; stores commit on the edge ending MEM; the stage never stalls and has no backpressure.
module dm_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] WD,
    input  logic [31:0] ALUOut_M,
    input  logic        MemWrite_M,
    input  logic        MemRead_M,
    input  logic [2:0]  MemOp_M,
    output logic [31:0] ReadData_W,
    output logic        MemErr_W
);

    localparam logic [2:0] OP_HU = 3'b001;
    localparam logic [2:0] OP_HS = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_BS = 3'b100;

    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic [AW-1:0] idx;
    logic          is_half;
    logic          is_byte;
    logic          is_signed;
    logic          in_range;
    logic          aligned;
    logic          legal;
    logic          do_store;
    logic          load_ok;
    logic          access;
    logic [3:0]    lane_en;
    logic [31:0]   lane_dat;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;
    logic [31:0]   ld_val;

    assign idx       = ALUOut_M[AW+1:2];
    assign is_half   = (MemOp_M == OP_HU) || (MemOp_M == OP_HS);
    assign is_byte   = (MemOp_M == OP_BU) || (MemOp_M == OP_BS);
    assign is_signed = (MemOp_M == OP_HS) || (MemOp_M == OP_BS);
    assign in_range  = (ALUOut_M[31:AW+2] == '0);
    assign aligned   = is_byte ? 1'b1 :
                       is_half ? (ALUOut_M[0] == 1'b0) :
                                 (ALUOut_M[1:0] == 2'b00);
    assign legal     = in_range && aligned;
    assign do_store  = MemWrite_M && legal;
    assign load_ok   = MemRead_M && !MemWrite_M && legal;
    assign access    = MemRead_M || MemWrite_M;

    // Store data is replicated across lanes so only the enable needs address decoding.
    always_comb begin
        lane_en  = 4'b1111;
        lane_dat = WD;
        if (is_byte) begin
            lane_en  = 4'b0001 << ALUOut_M[1:0];
            lane_dat = {4{WD[7:0]}};
        end else if (is_half) begin
            lane_en  = ALUOut_M[1] ? 4'b1100 : 4'b0011;
            lane_dat = {2{WD[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[idx][8*b +: 8] <= lane_dat[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[idx];
    assign rd_half = ALUOut_M[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (ALUOut_M[1:0])
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            2'b11:   rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    always_comb begin
        ld_val = rd_word;
        if (is_byte) begin
            ld_val = {{24{is_signed & rd_byte[7]}}, rd_byte};
        end else if (is_half) begin
            ld_val = {{16{is_signed & rd_half[15]}}, rd_half};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData_W <= '0;
            MemErr_W   <= 1'b0;
        end else begin
            ReadData_W <= load_ok ? ld_val : '0;
            MemErr_W   <= access && (!legal || (MemRead_M && MemWrite_M));
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Bench for dm_stage: vector table driven through a one-deep-latency scoreboard, plus an async reset sequence.
module tb_dm_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] WD;
    logic [31:0] ALUOut_M;
    logic        MemWrite_M;
    logic        MemRead_M;
    logic [2:0]  MemOp_M;
    logic [31:0] ReadData_W;
    logic        MemErr_W;

    int total;
    int bad;

    dm_stage #(.DEPTH_WORDS(1024), .AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .WD         (WD),
        .ALUOut_M   (ALUOut_M),
        .MemWrite_M (MemWrite_M),
        .MemRead_M  (MemRead_M),
        .MemOp_M    (MemOp_M),
        .ReadData_W (ReadData_W),
        .MemErr_W   (MemErr_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    exp_t sb [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemWrite_M = we;
        MemRead_M  = re;
        MemOp_M    = op;
        ALUOut_M   = addr;
        WD         = wd;
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard underflow: got empty expected entry");
        end else begin
            e = sb.pop_front();
            check32($sformatf("vec%0d rd", e.id), ReadData_W, e.rd);
            check1($sformatf("vec%0d err", e.id), MemErr_W, e.err);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //            we    re    op      addr          wd            rd            err
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0020, 32'h8765_4321, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0,        32'h8765_4321, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b011, 32'h0000_0023, 32'h0,        32'h0000_0087, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0023, 32'h0,        32'hFFFF_FF87, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0,        32'h0000_4321, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0022, 32'h0,        32'hFFFF_8765, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0,        32'h0000_8765, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0021, 32'h1234_56AB, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0,        32'h8765_AB21, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'hCAFE_BEEF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0,        32'hBEEF_AB21, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0,        32'hBEEF_AB21, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h0,        32'h0,         1'b1};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h1111_1111, 32'h0,        1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h0,        32'h1111_1111, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 3'b000, 32'h0000_0024, 32'h5A5A_5A5A, 32'h0,        1'b1};
        vecs[19] = '{1'b0, 1'b1, 3'b000, 32'h0000_0024, 32'h0,        32'h5A5A_5A5A, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 3'b000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[21] = '{1'b0, 1'b1, 3'b111, 32'h0000_0020, 32'h0,        32'hBEEF_AB21, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 3'b000, 32'h4000_0000, 32'h0,        32'h0,         1'b1};
        vecs[23] = '{1'b1, 1'b0, 3'b100, 32'h0000_0027, 32'h0000_007F, 32'h0,        1'b0};
        vecs[24] = '{1'b0, 1'b1, 3'b100, 32'h0000_0027, 32'h0,        32'h0000_007F, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 3'b000, 32'h0000_0024, 32'h0,        32'h7F5A_5A5A, 1'b0};
        vecs[26] = '{1'b0, 1'b1, 3'b001, 32'h0000_0026, 32'h0,        32'h0000_7F5A, 1'b0};
        vecs[27] = '{1'b1, 1'b0, 3'b000, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[28] = '{1'b0, 1'b1, 3'b000, 32'h0000_0FFC, 32'h0,        32'hDEAD_BEEF, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #12;
        check32("reset rd", ReadData_W, 32'h0);
        check1("reset err", MemErr_W, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (sb.size() != 0) pop_compare();
            drive(vecs[i].we, vecs[i].re, vecs[i].op, vecs[i].addr, vecs[i].wd);
            sb.push_back('{i, vecs[i].rd, vecs[i].err});
        end
        @(negedge clk);
        pop_compare();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Async reset mid-cycle with a store in flight.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0);
        @(negedge clk);
        check32("pre-reset rd", ReadData_W, 32'hBEEF_AB21);
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0030, 32'h1357_9BDF);
        #2;
        rst_n = 1'b0;
        #1;
        check32("async reset rd", ReadData_W, 32'h0);
        check1("async reset err", MemErr_W, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0030, 32'h0);
        @(negedge clk);
        check32("lost store rd", ReadData_W, 32'h0);
        check1("lost store err", MemErr_W, 1'b0);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0);
        @(negedge clk);
        check32("cleared mem rd", ReadData_W, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0030, 32'hA5A5_0F0F);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0030, 32'h0);
        @(negedge clk);
        check32("post-reset store rd", ReadData_W, 32'hA5A5_0F0F);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
